tdc_run_sequencer: RTL and testbench
====================================

// Module: tdc_run_sequencer
// PURPOSE
//  Sequences repeated TDC measurements: holds TDC in reset, arms it, waits for its done strobe,
//  captures the merged stamp into a FWFT FIFO and re-arms until N measurements complete.
//  Sits between the TDC top (drives its iRst/enable, reads oTDC/done) and the readout/UART logic.
//  Adds a per-measurement timeout so a missing hit cannot stall a run.
// PARAMETERS
//  DIG_OUT     32    width of TDC output word (matches `DIG_OUT)
//  FIFO_DEPTH  8     capture FIFO entries, power of 2, >=2
//  SETTLE      4     cycles oTdcRst held high before each arm, >=1
//  TIMEOUT     4096  cycles in ARM without done before abandon/retry, >=2
// PORTS
//  clk0       in   1        single clock for the block
//  iRst       in   1        synchronous, active-high reset
//  iStart     in   1        1-cycle pulse: begin a run (ignored unless IDLE)
//  iStop      in   1        abort run, return to IDLE
//  iNumMeas   in   16       measurements per run, sampled on iStart; 0 = continuous
//  oTdcRst    out  1        to TDC iRst
//  oTdcEnable out  1        to TDC enable
//  iTdcDone   in   1        TDC done strobe (1 cycle)
//  iTdcData   in   DIG_OUT  TDC oTDC, valid when iTdcDone=1
//  oData      out  DIG_OUT  FIFO head word
//  oValid     out  1        FIFO not empty
//  iReady     in   1        consumer accepts oData when oValid&iReady
//  oBusy      out  1        state != IDLE
//  oCount     out  16       measurements captured this run, saturates at 16'hFFFF
//  oTimeout   out  1        sticky: >=1 timeout this run
//  oOverflow  out  1        sticky: >=1 word dropped, FIFO full
// BEHAVIOUR
//  Reset (iRst=1 at clk0 edge): state IDLE, FIFO empty, oTdcRst=1, oTdcEnable=0, oValid=0,
//   oData=0, oBusy=0, oCount=0, oTimeout=0, oOverflow=0. All outputs registered.
//  FSM states IDLE, CLEAR, ARM:
//   IDLE : oTdcRst=1, oTdcEnable=0. iStart -> CLEAR; latch iNumMeas; clear oCount/oTimeout/oOverflow.
//   CLEAR: oTdcRst=1, oTdcEnable=0, settle counter runs; after exactly SETTLE cycles -> ARM.
//   ARM  : oTdcRst=0, oTdcEnable=1, timeout counter from 0.
//     iTdcDone=1 -> push iTdcData, oCount+1; if iNumMeas!=0 and new count==iNumMeas -> IDLE,
//       else -> CLEAR.
//     counter reaches TIMEOUT-1 without done -> oTimeout=1, no push, no count -> CLEAR (retry).
//  Priority: iRst > iStop > iTdcDone > timeout. iStop in CLEAR/ARM -> IDLE next cycle,
//   except iStop with iTdcDone same cycle: word pushed and counted, then IDLE.
//  iStart while oBusy=1 ignored. iStart and iStop same cycle in IDLE: stay IDLE.
//  FIFO (FWFT): push at edge N -> oValid=1, oData valid after edge N. Pop on oValid&iReady.
//   Full and push without pop: word dropped, oOverflow=1, oCount still increments.
//   Full with push and pop same cycle: both happen, no overflow. Empty: pop ignored.
//   FIFO contents survive iStop and new iStart; only iRst flushes it.
//  Counters: settle and timeout counters reset on every state entry; oCount saturates, no wrap.
//  Continuous mode (iNumMeas=0): cycles CLEAR/ARM until iStop.
// TESTING
//  1 iRst 3 cycles -> oTdcRst=1, oTdcEnable=0, oValid=0, oBusy=0, oCount=0, flags 0.
//  2 iNumMeas=3, iStart, model returns done+0xA,0xB,0xC -> 3 FIFO words in order, oCount=3,
//    oTdcRst high exactly SETTLE=4 cycles before each arm, IDLE after third.
//  3 iNumMeas=1, no done for 4096 ARM cycles -> oTimeout=1, re-enters CLEAR, oCount=0;
//    done on retry -> word pushed, IDLE.
//  4 iNumMeas=0, iReady=0, 9 dones -> 8 words stored, oOverflow=1, oCount=9;
//    then iReady=1 -> 8 words drain, first = first captured.
//  5 iStop asserted same cycle as iTdcDone in ARM -> word pushed, oCount+1, IDLE next cycle.
//  6 FIFO full, iReady=1 with done same cycle -> no overflow, occupancy stays 8.

Source files
------------

// File: rtl/tdc_run_sequencer.sv
// tdc_run_sequencer
//   Runs a series of TDC measurements. Each measurement holds the TDC in reset
//   for SETTLE cycles, then arms it and waits for its done strobe. The stamp is
//   captured into a first-word-fall-through FIFO, and the TDC is re-armed until
//   the requested number of measurements is reached. If an armed measurement
//   sees no done within TIMEOUT cycles, it is abandoned and retried.
//
// Ports
//   clk0        single clock
//   iRst        synchronous active-high reset (also flushes the FIFO)
//   iStart      begin a run (honoured only while idle)
//   iStop       abort the current run
//   iNumMeas    measurements per run, latched on iStart (0 = continuous)
//   oTdcRst     TDC reset
//   oTdcEnable  TDC enable
//   iTdcDone    TDC done strobe
//   iTdcData    TDC stamp, valid with iTdcDone
//   oData       FIFO head word
//   oValid      FIFO not empty
//   iReady      consumer accepts oData when oValid & iReady
//   oBusy       run in progress
//   oCount      measurements captured this run (saturating)
//   oTimeout    sticky: at least one timeout this run
//   oOverflow   sticky: at least one stamp dropped because the FIFO was full
module tdc_run_sequencer #(
    parameter int unsigned DIG_OUT    = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic               clk0,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iStop,
    input  logic [15:0]        iNumMeas,
    output logic               oTdcRst,
    output logic               oTdcEnable,
    input  logic               iTdcDone,
    input  logic [DIG_OUT-1:0] iTdcData,
    output logic [DIG_OUT-1:0] oData,
    output logic               oValid,
    input  logic               iReady,
    output logic               oBusy,
    output logic [15:0]        oCount,
    output logic               oTimeout,
    output logic               oOverflow
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned TMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int unsigned CW   = $clog2(TMAX);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARM} state_t;

    state_t              r_state, w_state_next;
    logic [CW-1:0]       r_tmr;
    logic [15:0]         r_num, r_count, w_count_inc;
    logic                r_tdc_rst, r_tdc_en, r_busy, r_tmo, r_ovf;
    logic                w_start, w_push, w_tmo;

    logic [DIG_OUT-1:0]  r_mem [FIFO_DEPTH];
    logic [DIG_OUT-1:0]  r_data, w_head;
    logic [AW:0]         r_wr, r_rd, w_wr_next, w_rd_next;
    logic                r_valid, w_full, w_pop, w_wr_en;

    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_push       = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart && !iStop) begin
                    w_start      = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (iStop)
                    w_state_next = S_IDLE;
                else if (r_tmr == CW'(SETTLE - 1))
                    w_state_next = S_ARM;
            end
            S_ARM: begin
                // A done that coincides with iStop is still captured.
                if (iTdcDone) begin
                    w_push = 1'b1;
                    if (iStop || (r_num != 16'd0 && w_count_inc == r_num))
                        w_state_next = S_IDLE;
                    else
                        w_state_next = S_CLEAR;
                end else if (iStop) begin
                    w_state_next = S_IDLE;
                end else if (r_tmr == CW'(TIMEOUT - 1)) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO bookkeeping. A push into a full FIFO is accepted only when a pop
    // frees a slot in the same cycle.
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop     = r_valid && iReady;
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_rd_next = r_rd + (AW+1)'(w_pop);
    assign w_wr_next = r_wr + (AW+1)'(w_wr_en);
    // The head is registered. When the word being written lands on the next
    // read slot, it becomes the head directly.
    assign w_head    = (w_wr_en && (w_rd_next[AW-1:0] == r_wr[AW-1:0]))
                       ? iTdcData : r_mem[w_rd_next[AW-1:0]];

    always_ff @(posedge clk0) begin
        if (w_wr_en)
            r_mem[r_wr[AW-1:0]] <= iTdcData;
    end

    always_ff @(posedge clk0) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_num     <= '0;
            r_count   <= '0;
            r_tdc_rst <= 1'b1;
            r_tdc_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo     <= 1'b0;
            r_ovf     <= 1'b0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tmr     <= (w_state_next != r_state || w_state_next == S_IDLE)
                         ? '0 : r_tmr + CW'(1);
            r_tdc_rst <= (w_state_next != S_ARM);
            r_tdc_en  <= (w_state_next == S_ARM);
            r_busy    <= (w_state_next != S_IDLE);
            if (w_start) begin
                r_num   <= iNumMeas;
                r_count <= '0;
                r_tmo   <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push)
                    r_count <= w_count_inc;
                if (w_tmo)
                    r_tmo <= 1'b1;
                if (w_push && w_full && !w_pop)
                    r_ovf <= 1'b1;
            end
            r_wr    <= w_wr_next;
            r_rd    <= w_rd_next;
            r_valid <= (w_wr_next != w_rd_next);
            if (w_wr_next != w_rd_next)
                r_data <= w_head;
        end
    end

    assign oTdcRst    = r_tdc_rst;
    assign oTdcEnable = r_tdc_en;
    assign oBusy      = r_busy;
    assign oCount     = r_count;
    assign oTimeout   = r_tmo;
    assign oOverflow  = r_ovf;
    assign oValid     = r_valid;
    assign oData      = r_data;

endmodule

// File: tb/tb_tdc_run_sequencer.sv
// tb_tdc_run_sequencer
//   Directed and randomized bench for tdc_run_sequencer. A transaction-level
//   reference (phase + age counters, a queue standing in for the FIFO) predicts
//   every output after each clock edge.
module tb_tdc_run_sequencer;
    localparam int unsigned DIG_OUT = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 4096;
    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_ARM   = 2;

    logic               clk0 = 1'b0;
    logic               rst = 1'b1, start = 1'b0, stop = 1'b0, done = 1'b0, ready = 1'b0;
    logic [15:0]        nmeas = '0;
    logic [DIG_OUT-1:0] data = '0;
    logic               oTdcRst, oTdcEnable, oValid, oBusy, oTimeout, oOverflow;
    logic [DIG_OUT-1:0] oData;
    logic [15:0]        oCount;

    int n_checks = 0;
    int n_err    = 0;

    // reference state
    int                 m_phase = P_IDLE;
    int                 m_age   = 0;
    int                 m_count = 0;
    int                 m_num   = 0;
    bit                 m_to    = 0;
    bit                 m_ov    = 0;
    logic [DIG_OUT-1:0] m_q[$];

    tdc_run_sequencer #(
        .DIG_OUT(DIG_OUT), .FIFO_DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk0(clk0), .iRst(rst), .iStart(start), .iStop(stop), .iNumMeas(nmeas),
        .oTdcRst(oTdcRst), .oTdcEnable(oTdcEnable), .iTdcDone(done), .iTdcData(data),
        .oData(oData), .oValid(oValid), .iReady(ready), .oBusy(oBusy),
        .oCount(oCount), .oTimeout(oTimeout), .oOverflow(oOverflow)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit pop;
        bit push;
        if (rst) begin
            m_phase = P_IDLE; m_age = 0; m_count = 0; m_num = 0;
            m_to = 0; m_ov = 0; m_q.delete();
            return;
        end
        pop  = (m_q.size() > 0) && (ready === 1'b1);
        push = 0;
        case (m_phase)
            P_IDLE: if (start && !stop) begin
                m_phase = P_CLEAR; m_age = 0; m_num = int'(nmeas);
                m_count = 0; m_to = 0; m_ov = 0;
            end
            P_CLEAR: begin
                if (stop) m_phase = P_IDLE;
                else if (m_age == SETTLE - 1) begin m_phase = P_ARM; m_age = 0; end
                else m_age++;
            end
            default: begin
                if (done) begin
                    push = 1;
                    m_count = (m_count == 65535) ? 65535 : m_count + 1;
                    if (stop || (m_num != 0 && m_count == m_num)) m_phase = P_IDLE;
                    else begin m_phase = P_CLEAR; m_age = 0; end
                end else if (stop) m_phase = P_IDLE;
                else if (m_age == TIMEOUT - 1) begin
                    m_to = 1; m_phase = P_CLEAR; m_age = 0;
                end else m_age++;
            end
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(data);
            else m_ov = 1;
        end
    endtask

    task automatic compare_all();
        chk("tdc_rst",  oTdcRst,    m_phase != P_ARM);
        chk("tdc_en",   oTdcEnable, m_phase == P_ARM);
        chk("busy",     oBusy,      m_phase != P_IDLE);
        chk("valid",    oValid,     m_q.size() > 0);
        chk("count",    oCount,     m_count);
        chk("timeout",  oTimeout,   m_to);
        chk("overflow", oOverflow,  m_ov);
        if (m_q.size() > 0) chk("data", oData, m_q[0]);
    endtask

    task automatic step();
        @(posedge clk0);
        model_update();
        #1;
        compare_all();
    endtask

    // Steps until the TDC is enabled, counting sampled cycles with oTdcRst high.
    task automatic wait_arm(output int rst_cyc);
        int k = 0;
        rst_cyc = 0;
        while (oTdcEnable !== 1'b1 && k < 10000) begin
            if (oTdcRst === 1'b1) rst_cyc++;
            step();
            k++;
        end
        chk("arm_reached", oTdcEnable, 1);
    endtask

    task automatic pulse_done(input logic [DIG_OUT-1:0] d);
        int rc;
        wait_arm(rc);
        done = 1'b1; data = d;
        step();
        done = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        ready = 1'b1;
        while (oValid === 1'b1 && k < 20) begin step(); k++; end
        ready = 1'b0;
        chk("drained", oValid, 0);
    endtask

    initial begin
        int rc;
        int n;
        logic [DIG_OUT-1:0] words [3];
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;

        // 1: reset
        rst = 1'b1;
        repeat (3) step();
        chk("rst_odata", oData, 0);
        chk("rst_tdcrst", oTdcRst, 1);
        rst = 1'b0;
        step();

        // start and stop together while idle: stay idle
        start = 1'b1; stop = 1'b1; nmeas = 16'd2;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", oBusy, 0);

        // 2: three measurements
        nmeas = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_arm(rc);
            chk("settle_cycles", rc, SETTLE);
            done = 1'b1; data = words[i];
            step();
            done = 1'b0;
        end
        chk("run3_count", oCount, 3);
        chk("run3_idle", oBusy, 0);
        chk("run3_head", oData, 32'hA);

        // 3: timeout then retry
        nmeas = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_arm(rc);
        repeat (TIMEOUT - 1) step();
        chk("tmo_still_armed", oTdcEnable, 1);
        chk("tmo_not_yet", oTimeout, 0);
        step();
        chk("tmo_flag", oTimeout, 1);
        chk("tmo_clear", oTdcRst, 1);
        chk("tmo_count", oCount, 0);
        pulse_done(32'hD00D);
        chk("retry_idle", oBusy, 0);
        chk("retry_count", oCount, 1);
        drain();

        // 4: continuous, consumer stalled, nine stamps
        nmeas = 16'd0; ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) pulse_done(32'h100 + i);
        chk("ovf_count", oCount, 9);
        chk("ovf_flag", oOverflow, 1);
        chk("ovf_head", oData, 32'h100);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_idle", oBusy, 0);

        // 6: full FIFO, push and pop in the same cycle
        start = 1'b1; step(); start = 1'b0;
        wait_arm(rc);
        ready = 1'b1; done = 1'b1; data = 32'h200;
        step();
        ready = 1'b0; done = 1'b0;
        chk("fullpp_no_ovf", oOverflow, 0);
        chk("fullpp_head", oData, 32'h101);
        stop = 1'b1; step(); stop = 1'b0;
        n = 0; ready = 1'b1;
        while (oValid === 1'b1 && n < 20) begin step(); n++; end
        ready = 1'b0;
        chk("fullpp_occupancy", n, DEPTH);

        // 5: stop together with done
        start = 1'b1; step(); start = 1'b0;
        wait_arm(rc);
        done = 1'b1; stop = 1'b1; data = 32'h5A5;
        step();
        done = 1'b0; stop = 1'b0;
        chk("stopdone_idle", oBusy, 0);
        chk("stopdone_count", oCount, 1);
        chk("stopdone_data", oData, 32'h5A5);
        step();
        drain();

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            nmeas = 16'($urandom_range(0, 5));
            ready = 1'($urandom_range(0, 1));
            start = 1'b1; step(); start = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (m_phase == P_IDLE) break;
                done  = (m_phase == P_ARM) && ($urandom_range(0, 2) == 0);
                data  = $urandom;
                ready = 1'($urandom_range(0, 1));
                stop  = (nmeas == 16'd0 && c > 150) || ($urandom_range(0, 199) == 0);
                start = ($urandom_range(0, 30) == 0);
                rst   = (r == 5 && c == 20);
                step();
                done = 1'b0; stop = 1'b0; start = 1'b0; rst = 1'b0;
            end
            chk("rand_idle", oBusy, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
